// File: rtl/conv_interleaver_pkg.sv
// Shared definitions for the convolutional interleaver.
//   - SYM_W       : soft-symbol width (signed, 8 bits)
//   - state_t     : controller states (CLEAR while the delay memory is being
//                   zeroed, RUN once symbols are accepted)
//   - il_depth()  : total delay-line cells, D*N*(N-1)/2
//   - il_addr_w() : width able to hold every address and every branch length
package conv_interleaver_pkg;

  localparam int SYM_W = 8;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic int il_depth(input int n, input int d);
    return d * n * (n - 1) / 2;
  endfunction

  // The +1 lets the widest branch length (which can equal the full depth when
  // N=2) be represented in the same width as the addresses.
  function automatic int il_addr_w(input int n, input int d);
    return $clog2(il_depth(n, d) + 1);
  endfunction

endpackage

// File: rtl/conv_il_ram.sv
// Single-port read-first block RAM with clock enable and 1-cycle read latency.
// Ports:
//   clk   : clock
//   en    : access enable; when low the read register holds its value
//   we    : write enable (qualified by en)
//   addr  : cell address
//   wdata : write data
//   rdata : old contents of addr, registered (read-first)
module conv_il_ram #(
  parameter int DEPTH = 6,
  parameter int AW    = 3,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset so this maps onto a
  // block RAM; clearing contents is a controller job, done cell by cell.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv_interleaver.sv
// Convolutional interleaver, transmit-side inverse of the LRPT deinterleaver.
// Symbol k is routed to branch b = k mod N; branch b is a ring of b*D cells
// in one shared RAM, so each symbol re-emerges b*D*N input symbols later.
// Branch 0 passes straight through. A symbol flagged first_in is forced onto
// branch 0 and the commutator resumes at branch 1.
//
// Optional build macro CONV_INTERLEAVER_CLEAR_EN: when defined, the block
// spends DEPTH cycles after reset writing zero into every cell before it
// accepts input. When undefined it enters RUN one cycle after reset and the
// delay-line fill contents are whatever the RAM held.
//
// Ports:
//   clk, sys_rst        : clock, synchronous active-high reset
//   soft_in[7:0]        : signed input symbol
//   valid_in            : input qualifier (soft_in, first_in, last_in)
//   first_in, last_in   : frame sideband, travels with the output slot
//   ready_in            : block accepts input this cycle
//   soft_out[7:0]       : signed interleaved symbol
//   valid_out           : output qualifier
//   first_out, last_out : sideband of the symbol accepted in this slot
//   ready_out           : downstream accepts output this cycle
module conv_interleaver
  import conv_interleaver_pkg::*;
#(
  parameter int BRANCH_COUNT = 36,
  parameter int BRANCH_DELAY = 64
) (
  input  logic                    clk,
  input  logic                    sys_rst,
  input  logic signed [SYM_W-1:0] soft_in,
  input  logic                    valid_in,
  input  logic                    first_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic signed [SYM_W-1:0] soft_out,
  output logic                    valid_out,
  output logic                    first_out,
  output logic                    last_out,
  input  logic                    ready_out
);

  localparam int DEPTH = il_depth(BRANCH_COUNT, BRANCH_DELAY);
  localparam int AW    = il_addr_w(BRANCH_COUNT, BRANCH_DELAY);
  localparam int BW    = $clog2(BRANCH_COUNT);

  state_t  state, state_nxt;
  logic    clearing;
  logic [AW-1:0] clr_cnt;

  // Commutator: current branch plus its base address and length, kept
  // incrementally so the address path needs only one adder.
  logic [BW-1:0] branch;
  logic [AW-1:0] base;
  logic [AW-1:0] len;
  logic [AW-1:0] ptr [BRANCH_COUNT];
  logic [AW-1:0] cur_ptr;
  logic          ptr_wrap;

  logic en;
  logic accept;
  logic route_b0;

  logic             ram_en;
  logic [AW-1:0]    ram_addr;
  logic [SYM_W-1:0] ram_wdata;
  logic [SYM_W-1:0] ram_rdata;

  logic                    s1_valid;
  logic                    s1_b0;
  logic signed [SYM_W-1:0] s1_soft;
  logic                    s1_first;
  logic                    s1_last;

  // Handshake: the whole pipeline advances together or holds together.
  assign en       = !valid_out || ready_out;
  assign ready_in = (state == ST_RUN) && en;
  assign accept   = valid_in && ready_in;
  assign route_b0 = first_in || (branch == '0);

  assign cur_ptr  = ptr[branch];
  assign ptr_wrap = (cur_ptr == len - AW'(1));

  // Controller ---------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (sys_rst) state <= ST_CLEAR;
    else         state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    clearing  = 1'b0;
    case (state)
      ST_CLEAR: begin
`ifdef CONV_INTERLEAVER_CLEAR_EN
        clearing = 1'b1;
        if (clr_cnt == AW'(DEPTH - 1)) state_nxt = ST_RUN;
`else
        state_nxt = ST_RUN;
`endif
      end
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst)       clr_cnt <= '0;
    else if (clearing) clr_cnt <= clr_cnt + AW'(1);
  end

  // Commutator and per-branch write pointers ---------------------------------
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      branch <= '0;
      base   <= '0;
      len    <= '0;
      for (int i = 0; i < BRANCH_COUNT; i++) ptr[i] <= '0;
    end else if (accept) begin
      if (!route_b0) ptr[branch] <= ptr_wrap ? '0 : cur_ptr + AW'(1);
      if (route_b0) begin
        // Branch 0 holds no cells, so branch 1 starts at base 0, length D.
        branch <= BW'(1);
        base   <= '0;
        len    <= AW'(BRANCH_DELAY);
      end else if (branch == BW'(BRANCH_COUNT - 1)) begin
        branch <= '0;
        base   <= '0;
        len    <= '0;
      end else begin
        branch <= branch + BW'(1);
        base   <= base + len;
        len    <= len + AW'(BRANCH_DELAY);
      end
    end
  end

  // Delay memory: one read-before-write per delayed symbol, or a zero fill
  // write per cycle while clearing.
  assign ram_en    = clearing || (accept && !route_b0);
  assign ram_addr  = clearing ? clr_cnt : base + cur_ptr;
  assign ram_wdata = clearing ? '0 : soft_in;

  conv_il_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (SYM_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_en),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Stage 1: runs alongside the RAM access, remembers the slot's sideband
  // and whether the slot bypasses the memory.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      s1_valid <= 1'b0;
      s1_b0    <= 1'b0;
      s1_soft  <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      s1_b0    <= route_b0;
      s1_soft  <= soft_in;
      s1_first <= first_in;
      s1_last  <= last_in;
    end
  end

  // Stage 2: output register.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      valid_out <= 1'b0;
      soft_out  <= '0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
    end else if (en) begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        soft_out  <= s1_b0 ? s1_soft : $signed(ram_rdata);
        first_out <= s1_first;
        last_out  <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_conv_interleaver.sv
// Self-checking bench for conv_interleaver with N=3, D=2.
// The reference keeps one FIFO per branch (branch b pre-filled with b*D
// cells) and a commutator counter; each accepted symbol pops the expected
// output from its branch FIFO. A monitor compares every output transfer
// against that model and also runs the outputs through a deinterleaver model
// to confirm the input stream is recovered after the fill delay.
module tb_conv_interleaver;

  localparam int N     = 3;
  localparam int D     = 2;
  localparam int DEPTH = D * N * (N - 1) / 2;
  localparam int FILL  = N * (N - 1) * D;
`ifdef CONV_INTERLEAVER_CLEAR_EN
  localparam int CLR_CYC       = DEPTH;
  localparam bit PREFILL_KNOWN = 1'b1;
`else
  localparam int CLR_CYC       = 1;
  localparam bit PREFILL_KNOWN = 1'b0;
`endif

  logic              clk;
  logic              sys_rst;
  logic signed [7:0] soft_in;
  logic              valid_in;
  logic              first_in;
  logic              last_in;
  logic              ready_in;
  logic signed [7:0] soft_out;
  logic              valid_out;
  logic              first_out;
  logic              last_out;
  logic              ready_out;

  conv_interleaver #(
    .BRANCH_COUNT (N),
    .BRANCH_DELAY (D)
  ) dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .soft_in   (soft_in),
    .valid_in  (valid_in),
    .first_in  (first_in),
    .last_in   (last_in),
    .ready_in  (ready_in),
    .soft_out  (soft_out),
    .valid_out (valid_out),
    .first_out (first_out),
    .last_out  (last_out),
    .ready_out (ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model ----------------------------------------------------------
  typedef struct {
    byte v;
    bit  k;
    bit  f;
    bit  l;
  } exp_t;

  int   comm;
  byte  fifo_v [N][$];
  bit   fifo_k [N][$];
  exp_t exp_q[$];
  byte  cap_v[$];
  bit   cap_f[$];
  byte  in_hist[$];
  byte  deint [N][$];
  int   lb_k;
  bit   lb_on;
  int   rdy_mode;
  int   first_acc_cyc;
  int   first_out_cyc;

  task automatic model_reset();
    comm = 0;
    for (int b = 0; b < N; b++) begin
      fifo_v[b].delete();
      fifo_k[b].delete();
      deint[b].delete();
      for (int c = 0; c < b * D; c++) begin
        fifo_v[b].push_back(8'sd0);
        fifo_k[b].push_back(PREFILL_KNOWN);
      end
    end
    exp_q.delete();
    cap_v.delete();
    cap_f.delete();
    in_hist.delete();
    lb_k = 0;
  endtask

  task automatic model_accept(input byte v, input bit f, input bit l);
    int   b;
    exp_t e;
    b    = f ? 0 : comm;
    comm = (b + 1) % N;
    e.f  = f;
    e.l  = l;
    if (b == 0) begin
      e.v = v;
      e.k = 1'b1;
    end else begin
      e.v = fifo_v[b].pop_front();
      e.k = fifo_k[b].pop_front();
      fifo_v[b].push_back(v);
      fifo_k[b].push_back(1'b1);
    end
    exp_q.push_back(e);
    in_hist.push_back(v);
  endtask

  // Downstream ready pattern.
  always @(negedge clk) begin
    case (rdy_mode)
      0:       ready_out = 1'b1;
      1:       ready_out = cyc[0];
      default: ready_out = ($urandom_range(0, 9) < 7);
    endcase
  end

  // Compare process: one check set per output transfer.
  always @(negedge clk) begin : mon
    exp_t e;
    int   j;
    byte  rec;
    #2;
    if (!sys_rst && valid_out && ready_out) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      cap_v.push_back(soft_out);
      cap_f.push_back(first_out);
      check("expectation_available", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.k) check("soft_out", soft_out, e.v);
        check("first_out", first_out, e.f);
        check("last_out", last_out, e.l);
      end
      if (lb_on) begin
        j = lb_k % N;
        rec = 0;
        deint[j].push_back(soft_out);
        if (deint[j].size() > (N - 1 - j) * D) rec = deint[j].pop_front();
        if (lb_k >= FILL) check("loopback", rec, in_hist[lb_k - FILL]);
        lb_k++;
      end
    end
  end

  // Stimulus tasks -----------------------------------------------------------
  task automatic send(input byte v, input bit f, input bit l);
    bit acc;
    int t;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 100) begin
      @(negedge clk);
      valid_in = 1'b1;
      soft_in  = v;
      first_in = f;
      last_in  = l;
      #1;
      acc = ready_in;
      if (acc && first_acc_cyc < 0) first_acc_cyc = cyc;
      @(posedge clk);
      t++;
    end
    if (acc) model_accept(v, f, l);
    else     check("send_accepted", acc, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
    first_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    valid_in = 1'b0;
    first_in = 1'b0;
    last_in  = 1'b0;
    rdy_mode = 0;
    while (exp_q.size() > 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    #3;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    int lows;
    @(negedge clk);
    sys_rst  = 1'b1;
    valid_in = 1'b0;
    first_in = 1'b0;
    last_in  = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    #1;
    check("reset_valid_out", valid_out, 0);
    check("reset_ready_in", ready_in, 0);
    check("reset_sideband_soft", {first_out, last_out, soft_out}, 0);
    model_reset();
    sys_rst = 1'b0;
    lows = 0;
    while (!ready_in && lows < 100) begin
      check("clear_outputs_zero", {valid_out, first_out, last_out, soft_out}, 0);
      lows++;
      @(negedge clk);
      #1;
    end
    check("clear_cycles", lows, CLR_CYC);
  endtask

  task automatic stream(input int n, input int first_at);
    for (int v = 1; v <= n; v++) send(byte'(v), v == first_at, v == n);
  endtask

  task automatic check_literal(input string tag);
    byte lit [18];
    lit = '{1, 0, 0, 4, 0, 0, 7, 2, 0, 10, 5, 0, 13, 8, 3, 16, 11, 6};
    check({tag, "_count"}, cap_v.size(), 30);
    if (cap_v.size() >= 18) begin
      for (int i = 0; i < 18; i++)
        if (lit[i] != 0 || PREFILL_KNOWN) check(tag, cap_v[i], lit[i]);
    end
  endtask

  // Test sequence ------------------------------------------------------------
  initial begin
    sys_rst       = 1'b1;
    valid_in      = 1'b0;
    soft_in       = '0;
    first_in      = 1'b0;
    last_in       = 1'b0;
    rdy_mode      = 0;
    lb_on         = 1'b0;
    first_acc_cyc = -1;
    first_out_cyc = -1;
    model_reset();

    // Power-on reset, clear phase, then the basic ramp with full throughput.
    do_reset();
    stream(30, 0);
    drain();
    check("latency", first_out_cyc - first_acc_cyc, 2);
    check_literal("seq_full");

    // Same ramp under downstream backpressure on alternate cycles.
    do_reset();
    rdy_mode = 1;
    stream(30, 0);
    drain();
    check_literal("seq_toggle");

    // first_in on the fifth symbol forces it onto branch 0.
    do_reset();
    stream(12, 5);
    drain();
    check("first_slot_value", cap_v[4], 5);
    check("first_slot_flag", cap_f[4], 1);
    check("pre_first_flag", cap_f[3], 0);
    check("after_first_b0", cap_v[7], 8);
    check("after_first_b1", cap_v[8], 2);

    // Reset with two symbols in flight, then restart from scratch.
    do_reset();
    stream(10, 0);
    do_reset();
    stream(30, 0);
    drain();
    check_literal("seq_after_reset");

    // Random signed data with gaps and random backpressure, looped back
    // through the deinterleaver model.
    do_reset();
    lb_on    = 1'b1;
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send(byte'($urandom), 1'b0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    drain();
    lb_on = 1'b0;
    check("loopback_slots", lb_k, 300);

    // Random stream with occasional frame starts.
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      send(byte'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 4) == 0) idle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_interleaver.md
CONV_INTERLEAVER -- requirements
Module: conv_interleaver

Interface
REQ-001 Parameter BRANCH_COUNT, default 36: number of commutator branches (N), range 2..64.
REQ-002 Parameter BRANCH_DELAY, default 64: delay increment per branch in cells (D), range 1..2048; branch i holds i*D cells.
REQ-003 Clocking is fixed: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 sys_rst  in  1  synchronous active-high reset.
REQ-006 soft_in  in  8  signed soft symbol to interleave.
REQ-007 valid_in  in  1  soft_in/first_in/last_in valid.
REQ-008 first_in  in  1  marks first symbol of a frame.
REQ-009 last_in  in  1  marks last symbol of a frame.
REQ-010 ready_in  out  1  block accepts input this cycle.
REQ-011 soft_out  out  8  signed interleaved symbol.
REQ-012 valid_out  out  1  soft_out/first_out/last_out valid.
REQ-013 first_out, last_out  out  1 each  first_in/last_in of the accepted symbol in the same slot.
REQ-014 ready_out  in  1  downstream accepts output this cycle.

Function
REQ-015 The block SHALL be the transmit-side inverse of the LRPT convolutional deinterleaver: stream symbol k goes to branch b = k mod N; output slot k carries the symbol entered on branch b exactly b*D*N input symbols earlier (branch 0 passes through).
REQ-016 Memory SHALL hold D*N*(N-1)/2 cells; branch i occupies base B(i)=D*i*(i-1)/2, length L(i)=i*D.
REQ-017 Per branch, a write pointer SHALL read-before-write the cell at B(i)+ptr(i), then advance ptr(i), wrapping from L(i)-1 to 0.
REQ-018 B and L of the current branch SHALL be tracked incrementally (B+=L, L+=D on advance; both cleared on wrap to branch 0); no multiplier in the address path.
REQ-019 States: CLEAR, RUN. CLEAR -> RUN when the clear counter reaches depth-1; RUN is held until sys_rst.
REQ-020 Pipeline: stage 1 = RAM access, stage 2 = output register; advance enable en = !valid_out || ready_out.
REQ-021 ready_in SHALL equal (state==RUN) && en; a symbol accepted at cycle T appears on valid_out at T+2 if ready_out stays high.
REQ-022 When en is low, RAM enable, commutator, pointers and both stages SHALL hold; no symbol dropped or duplicated.
REQ-023 An accepted symbol with first_in=1 SHALL be forced onto branch 0 and the commutator continues from branch 1; pointers are not reset.
REQ-024 first_out/last_out SHALL be the sideband of the accepted symbol in the same slot, not delayed by branch.
REQ-025 valid_in while ready_in is low SHALL be ignored; soft_in SHALL not be interpreted as unsigned anywhere.

Reset
REQ-026 On sys_rst: valid_out=0, soft_out=0, first_out=0, last_out=0, ready_in=0, commutator=0, all ptr=0, B=0, L=0, stage-1 valid=0.
REQ-027 Reset mid-operation SHALL discard all in-flight symbols in the next cycle.

Configuration
REQ-028 Macro CONV_INTERLEAVER_CLEAR_EN defined: after reset the block SHALL stay in CLEAR for exactly depth cycles writing 0 to every cell; pre-fill outputs are 0.
REQ-029 Macro undefined: reset SHALL enter RUN directly (ready_in=1 the cycle after reset release); pre-fill outputs are unspecified.

Structure
REQ-030 Package conv_interleaver_pkg SHALL hold the state enum, the depth/address-width functions and the symbol width constant (8).
REQ-031 Sub-module conv_il_ram SHALL be a single-port read-first BRAM with enable, 1-cycle read latency.

Verification (N=3, D=2, CONV_INTERLEAVER_CLEAR_EN defined unless stated)
REQ-032 Reset, then count cycles -> ready_in low exactly 6 cycles, then high; all outputs 0 throughout.
REQ-033 Feed 1,2,3,...,30 with ready_out=1 -> outputs 1,0,0,4,0,0,7,2,0,10,5,0,13,8,3,16,11,6,...; first output 2 cycles after acceptance.
REQ-034 Same stream, ready_out toggled every other cycle -> identical output sequence, none lost or duplicated.
REQ-035 first_in=1 on input 5 (would be branch 1) -> it exits on branch 0 slot immediately (value 5), next input uses branch 1; first_out=1 on that slot.
REQ-036 sys_rst pulsed mid-stream with 2 symbols in flight -> valid_out=0 next cycle, CLEAR repeats, subsequent stream matches REQ-033 from scratch.
REQ-037 Loopback through the deinterleaver model with N=36, D=64 on random signed data -> recovered stream equals input after N*(N-1)*D fill symbols.
